// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU register bus between a host and the UART receive FIFO
// Signals:
//   access_addr  host -> fifo  register address
//   reg_r_en     host -> fifo  read strobe, one cycle per access
//   reg_w_en     host -> fifo  write strobe, one cycle per access
//   wr_data      host -> fifo  write data
//   rd_data      fifo -> host  registered read data
//   int_req      fifo -> host  interrupt request, data pending
//   fifo_empty   fifo -> host  live empty status
//   fifo_full    fifo -> host  live full status
//   overflow     fifo -> host  sticky overflow status
interface uart_rx_fifo_if;
    logic [7:0] access_addr;
    logic       reg_r_en;
    logic       reg_w_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       int_req;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    modport master (
        output access_addr, reg_r_en, reg_w_en, wr_data,
        input  rd_data, int_req, fifo_empty, fifo_full, overflow
    );
    modport slave (
        input  access_addr, reg_r_en, reg_w_en, wr_data,
        output rd_data, int_req, fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers bytes from a serial receiver and exposes them via CPU registers
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_rx_byte  received byte from the serial receiver
//   i_rx_flag  byte-valid flag; each rising transition pushes i_rx_byte
//   bus        CPU register bus (slave side): data register pops, status register reads/clears/flushes
module uart_rx_fifo #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] DATA_ADDR = 8'd253,
    parameter logic [7:0] STAT_ADDR = 8'd254
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_rx_byte,
    input  logic          i_rx_flag,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic          r_flag_d;
    logic [7:0]    r_rd_data;
    logic          r_overflow;
    logic          r_int_req;

    logic w_push, w_pop, w_stat_rd, w_stat_wr, w_flush, w_clr_ov;
    logic w_empty, w_full, w_rd, w_wr, w_ovf;

    assign w_push    = i_rx_flag & ~r_flag_d;
    assign w_pop     = bus.reg_r_en & (bus.access_addr == DATA_ADDR);
    assign w_stat_rd = bus.reg_r_en & (bus.access_addr == STAT_ADDR);
    assign w_stat_wr = bus.reg_w_en & (bus.access_addr == STAT_ADDR);
    assign w_flush   = w_stat_wr & bus.wr_data[0];
    assign w_clr_ov  = w_stat_wr & bus.wr_data[7];
    assign w_empty   = (r_count == 4'd0);
    assign w_full    = (r_count == 4'(DEPTH));
    assign w_rd      = w_pop & ~w_empty;
    // A full FIFO still accepts a push when the same cycle pops; a flush drops the push outright
    assign w_wr      = w_push & (~w_full | w_rd) & ~w_flush;
    assign w_ovf     = w_push & w_full & ~w_rd & ~w_flush;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 4'd0;
            r_flag_d   <= 1'b1;
            r_rd_data  <= 8'h00;
            r_overflow <= 1'b0;
            r_int_req  <= 1'b0;
        end else begin
            r_flag_d  <= i_rx_flag;
            r_int_req <= ~w_empty;
            if (w_pop) r_rd_data <= w_empty ? 8'h00 : r_mem[r_rd_ptr];
            else if (w_stat_rd) r_rd_data <= {r_overflow, w_full, w_empty, 1'b0, r_count};
            // Set wins over clear when an overflow coincides with a clear request
            r_overflow <= w_ovf | (r_overflow & ~w_clr_ov);
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= 4'd0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + {3'b0, w_wr} - {3'b0, w_rd};
            end
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.int_req    = r_int_req;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH=8)
module tb_uart_rx_fifo;
    localparam logic [7:0] DA = 8'd253;
    localparam logic [7:0] SA = 8'd254;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_flag = 1'b0;
    int         errors = 0;
    int         checks = 0;

    uart_rx_fifo_if bus ();

    uart_rx_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx_byte (rx_byte),
        .i_rx_flag (rx_flag),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_byte = b;
        rx_flag = 1'b1;
        tick();
        rx_flag = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [7:0] a);
        bus.access_addr = a;
        bus.reg_r_en = 1'b1;
        tick();
        bus.reg_r_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.access_addr = a;
        bus.wr_data = d;
        bus.reg_w_en = 1'b1;
        tick();
        bus.reg_w_en = 1'b0;
    endtask

    initial begin
        bus.access_addr = 8'h00;
        bus.reg_r_en = 1'b0;
        bus.reg_w_en = 1'b0;
        bus.wr_data = 8'h00;
        tick(3);
        chk("rst_rd_data", bus.rd_data, 8'h00);
        chk("rst_int_req", bus.int_req, 1'b0);
        chk("rst_empty", bus.fifo_empty, 1'b1);
        chk("rst_full", bus.fifo_full, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        rst_n = 1'b1;
        tick(2);

        push(8'h41);
        push(8'h42);
        chk("two_int_req", bus.int_req, 1'b1);
        rd(DA);
        chk("two_rd0", bus.rd_data, 8'h41);
        rd(DA);
        chk("two_rd1", bus.rd_data, 8'h42);
        chk("two_int_lag", bus.int_req, 1'b1);
        tick();
        chk("two_int_low", bus.int_req, 1'b0);
        chk("two_empty", bus.fifo_empty, 1'b1);
        rd(DA);
        chk("empty_pop", bus.rd_data, 8'h00);

        for (int i = 1; i <= 9; i++) push(8'(i));
        chk("ovf_full", bus.fifo_full, 1'b1);
        chk("ovf_flag", bus.overflow, 1'b1);
        rd(SA);
        chk("ovf_status", bus.rd_data, 8'hC8);
        rd(8'h10);
        chk("other_hold", bus.rd_data, 8'hC8);
        for (int i = 1; i <= 8; i++) begin
            rd(DA);
            chk("ovf_drain", bus.rd_data, 8'(i));
        end
        chk("ovf_empty", bus.fifo_empty, 1'b1);
        wr(SA, 8'h80);
        chk("ovf_clear", bus.overflow, 1'b0);

        rx_byte = 8'h55;
        rx_flag = 1'b1;
        tick(5);
        rx_flag = 1'b0;
        tick();
        rd(SA);
        chk("hold_status", bus.rd_data, 8'h01);
        rd(DA);
        chk("hold_data", bus.rd_data, 8'h55);

        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        rx_byte = 8'hAA;
        rx_flag = 1'b1;
        bus.access_addr = DA;
        bus.reg_r_en = 1'b1;
        tick();
        rx_flag = 1'b0;
        bus.reg_r_en = 1'b0;
        chk("fullpp_rd", bus.rd_data, 8'h10);
        tick();
        rd(SA);
        chk("fullpp_status", bus.rd_data, 8'h48);
        for (int i = 1; i < 8; i++) begin
            rd(DA);
            chk("fullpp_drain", bus.rd_data, 8'h10 + 8'(i));
        end
        rd(DA);
        chk("fullpp_last", bus.rd_data, 8'hAA);

        rx_byte = 8'h5A;
        rx_flag = 1'b1;
        bus.access_addr = DA;
        bus.reg_r_en = 1'b1;
        tick();
        rx_flag = 1'b0;
        bus.reg_r_en = 1'b0;
        chk("emptypp_rd", bus.rd_data, 8'h00);
        tick();
        rd(SA);
        chk("emptypp_status", bus.rd_data, 8'h01);
        rd(DA);
        chk("emptypp_data", bus.rd_data, 8'h5A);

        for (int i = 0; i < 9; i++) push(8'h20 + 8'(i));
        for (int i = 0; i < 5; i++) rd(DA);
        chk("pre_flush_rd", bus.rd_data, 8'h24);
        rd(SA);
        chk("pre_flush_status", bus.rd_data, 8'h83);
        wr(SA, 8'h81);
        chk("flush_empty", bus.fifo_empty, 1'b1);
        chk("flush_overflow", bus.overflow, 1'b0);
        tick();
        chk("flush_int_req", bus.int_req, 1'b0);
        rd(SA);
        chk("flush_status", bus.rd_data, 8'h20);

        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        rx_byte = 8'hEE;
        rx_flag = 1'b1;
        wr(SA, 8'h80);
        rx_flag = 1'b0;
        chk("set_wins", bus.overflow, 1'b1);
        tick();
        rx_flag = 1'b1;
        wr(SA, 8'h81);
        rx_flag = 1'b0;
        chk("flush_push_ovf", bus.overflow, 1'b0);
        chk("flush_push_empty", bus.fifo_empty, 1'b1);
        tick();

        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        rx_byte = 8'h77;
        rx_flag = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_empty", bus.fifo_empty, 1'b1);
        chk("async_int_req", bus.int_req, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        rd(SA);
        chk("rst_rel_status", bus.rd_data, 8'h20);
        chk("rst_rel_int_req", bus.int_req, 1'b0);
        rx_flag = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
